// File: rtl/xadc_drp_sampler_pkg.sv
// -----------------------------------------------------------------------------
// xadc_drp_package
// Shared types and constants for the XADC DRP sampler slice.
//   - xadc_drp_sampler_state_t : sequencing states of the sampler FSM
//   - XADC_DRP_ADDR_*          : default DRP result-register addresses
//   - XADC_DRP_SAMPLE_*_IDX    : where the 12-bit conversion sits in a DRP word
// -----------------------------------------------------------------------------
package xadc_drp_package;

    typedef enum logic [1:0] {
        SAMPLER_IDLE         = 2'd0,
        SAMPLER_WAIT_VOLTAGE = 2'd1,
        SAMPLER_WAIT_CURRENT = 2'd2,
        SAMPLER_COMMIT       = 2'd3
    } xadc_drp_sampler_state_t;

    localparam logic [6:0] XADC_DRP_ADDR_VPVN  = 7'h03;
    localparam logic [6:0] XADC_DRP_ADDR_VAUX0 = 7'h10;

    // The XADC left-justifies its 12-bit result inside the 16-bit DRP word.
    localparam int XADC_DRP_SAMPLE_MSB_IDX = 15;
    localparam int XADC_DRP_SAMPLE_LSB_IDX = 4;

endpackage

// File: rtl/xadc_drp_sampler_read_port.sv
// -----------------------------------------------------------------------------
// xadc_drp_read_port
// Single DRP read engine shared by the voltage and current reads. Generates the
// den pulse, keeps drp_daddr stable between requests, runs the per-wait timeout
// counter and qualifies drdy into a completion strobe.
//   clk, rst          : clock, asynchronous active-low reset
//   req, req_addr     : issue a read this cycle to req_addr
//   waiting           : owner is waiting for read data
//   drp_den/daddr     : DRP request side
//   drp_do/drdy       : DRP response side
//   rd_done, rd_data  : read completed this cycle, with its data
//   rd_timeout        : wait expired this cycle without drdy
// -----------------------------------------------------------------------------
module xadc_drp_read_port #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [6:0]  req_addr,
    input  logic        waiting,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        rd_done,
    output logic [15:0] rd_data,
    output logic        rd_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]       daddr_q, daddr_d;

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        daddr_d    = req ? req_addr : daddr_q;
        drp_den    = req;
        // The address goes out in the same cycle as den and then holds.
        drp_daddr  = daddr_d;
        rd_done    = waiting && drp_drdy;
        rd_data    = drp_do;
        // drdy wins over an expiring counter on the last allowed cycle.
        rd_timeout = waiting && !drp_drdy && (wait_cnt_q == CNT_LAST);

        wait_cnt_d = wait_cnt_q;
        if (req) begin
            wait_cnt_d = '0;
        end else if (waiting && !drp_drdy && !rd_timeout) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            daddr_q    <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            daddr_q    <= daddr_d;
        end
    end

endmodule

// File: rtl/xadc_drp_sampler.sv
// -----------------------------------------------------------------------------
// xadc_drp_sampler
// On each XADC end-of-sequence pulse, reads the voltage and current-monitor
// result registers over DRP and publishes the pair on two AXI-Stream sources.
// A pair is committed to both streams in the same cycle or dropped entirely.
//   clk, rst                      : clock, asynchronous active-low reset
//   eos                           : XADC end-of-sequence pulse
//   drp_*                         : DRP master port (read-only)
//   voltage_t*, current_t*        : AXI-Stream sources, raw 16-bit DRP words
//   overrun_count                 : saturating count of dropped pairs
//   drp_timeout                   : sticky DRP read timeout flag
//   busy                          : sampler is not idle
// -----------------------------------------------------------------------------
module xadc_drp_sampler
    import xadc_drp_package::*;
#(
    parameter logic [6:0] VOLTAGE_CHANNEL_ADDR = XADC_DRP_ADDR_VPVN,
    parameter logic [6:0] CURRENT_CHANNEL_ADDR = XADC_DRP_ADDR_VAUX0,
    parameter int         DRP_TIMEOUT_CYCLES   = 64,
    parameter int         OVERRUN_COUNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           eos,
    output logic [6:0]                     drp_daddr,
    output logic                           drp_den,
    output logic                           drp_dwe,
    output logic [15:0]                    drp_di,
    input  logic [15:0]                    drp_do,
    input  logic                           drp_drdy,
    output logic [15:0]                    voltage_tdata,
    output logic                           voltage_tvalid,
    input  logic                           voltage_tready,
    output logic [15:0]                    current_tdata,
    output logic                           current_tvalid,
    input  logic                           current_tready,
    output logic [OVERRUN_COUNT_WIDTH-1:0] overrun_count,
    output logic                           drp_timeout,
    output logic                           busy
);

    xadc_drp_sampler_state_t state_q, state_d;

    logic                           eos_q, pending_q, pending_d;
    logic [15:0]                    voltage_hold_q, voltage_hold_d;
    logic [15:0]                    current_hold_q, current_hold_d;
    logic [15:0]                    voltage_tdata_q, voltage_tdata_d;
    logic [15:0]                    current_tdata_q, current_tdata_d;
    logic                           voltage_tvalid_q, voltage_tvalid_d;
    logic                           current_tvalid_q, current_tvalid_d;
    logic [OVERRUN_COUNT_WIDTH-1:0] overrun_q, overrun_d;
    logic                           timeout_q, timeout_d;

    logic        trigger, rd_req, rd_waiting, rd_done, rd_timeout;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;
    logic        free_v, free_c;

    // eos is registered once; this sets den(V) one cycle after the pulse.
    assign trigger = eos_q || pending_q;

    xadc_drp_read_port #(
        .TIMEOUT_CYCLES (DRP_TIMEOUT_CYCLES)
    ) u_read_port (
        .clk        (clk),
        .rst        (rst),
        .req        (rd_req),
        .req_addr   (rd_addr),
        .waiting    (rd_waiting),
        .drp_den    (drp_den),
        .drp_daddr  (drp_daddr),
        .drp_do     (drp_do),
        .drp_drdy   (drp_drdy),
        .rd_done    (rd_done),
        .rd_data    (rd_data),
        .rd_timeout (rd_timeout)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SAMPLER_IDLE;
        else      state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SAMPLER_IDLE:         if (trigger) state_d = SAMPLER_WAIT_VOLTAGE;
            SAMPLER_WAIT_VOLTAGE: if (rd_done) state_d = SAMPLER_WAIT_CURRENT;
                                  else if (rd_timeout) state_d = SAMPLER_IDLE;
            SAMPLER_WAIT_CURRENT: if (rd_done) state_d = SAMPLER_COMMIT;
                                  else if (rd_timeout) state_d = SAMPLER_IDLE;
            SAMPLER_COMMIT:       state_d = SAMPLER_IDLE;
            default:              state_d = SAMPLER_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    // The current read is issued in the same cycle the voltage data lands.
    always_comb begin
        rd_req     = ((state_q == SAMPLER_IDLE) && trigger) ||
                     ((state_q == SAMPLER_WAIT_VOLTAGE) && rd_done);
        rd_addr    = (state_q == SAMPLER_IDLE) ? VOLTAGE_CHANNEL_ADDR : CURRENT_CHANNEL_ADDR;
        rd_waiting = (state_q == SAMPLER_WAIT_VOLTAGE) || (state_q == SAMPLER_WAIT_CURRENT);
        busy       = (state_q != SAMPLER_IDLE);
    end

    // ---- Datapath ----
    always_comb begin
        free_v = !voltage_tvalid_q || voltage_tready;
        free_c = !current_tvalid_q || current_tready;

        // Only one sequence is queued; the idle cycle that launches it clears it.
        pending_d = pending_q;
        if (state_q == SAMPLER_IDLE) pending_d = 1'b0;
        else if (eos_q)              pending_d = 1'b1;

        voltage_hold_d = voltage_hold_q;
        current_hold_d = current_hold_q;
        if (rd_done && (state_q == SAMPLER_WAIT_VOLTAGE)) voltage_hold_d = rd_data;
        if (rd_done && (state_q == SAMPLER_WAIT_CURRENT)) current_hold_d = rd_data;
        if (rd_timeout) begin
            voltage_hold_d = '0;
            current_hold_d = '0;
        end
        timeout_d = timeout_q || rd_timeout;

        voltage_tdata_d  = voltage_tdata_q;
        current_tdata_d  = current_tdata_q;
        voltage_tvalid_d = voltage_tvalid_q && !voltage_tready;
        current_tvalid_d = current_tvalid_q && !current_tready;
        overrun_d        = overrun_q;

        if (state_q == SAMPLER_COMMIT) begin
            if (free_v && free_c) begin
                voltage_tdata_d  = voltage_hold_q;
                current_tdata_d  = current_hold_q;
                voltage_tvalid_d = 1'b1;
                current_tvalid_d = 1'b1;
            end else if (overrun_q != '1) begin
                overrun_d = overrun_q + OVERRUN_COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eos_q            <= 1'b0;
            pending_q        <= 1'b0;
            voltage_hold_q   <= '0;
            current_hold_q   <= '0;
            voltage_tdata_q  <= '0;
            current_tdata_q  <= '0;
            voltage_tvalid_q <= 1'b0;
            current_tvalid_q <= 1'b0;
            overrun_q        <= '0;
            timeout_q        <= 1'b0;
        end else begin
            eos_q            <= eos;
            pending_q        <= pending_d;
            voltage_hold_q   <= voltage_hold_d;
            current_hold_q   <= current_hold_d;
            voltage_tdata_q  <= voltage_tdata_d;
            current_tdata_q  <= current_tdata_d;
            voltage_tvalid_q <= voltage_tvalid_d;
            current_tvalid_q <= current_tvalid_d;
            overrun_q        <= overrun_d;
            timeout_q        <= timeout_d;
        end
    end

    assign drp_dwe        = 1'b0;
    assign drp_di         = '0;
    assign voltage_tdata  = voltage_tdata_q;
    assign voltage_tvalid = voltage_tvalid_q;
    assign current_tdata  = current_tdata_q;
    assign current_tvalid = current_tvalid_q;
    assign overrun_count  = overrun_q;
    assign drp_timeout    = timeout_q;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_sampler
// Directed bench for xadc_drp_sampler. A zero-wait DRP responder answers each
// den with the word for the requested address one cycle later. A second
// instance with a 4-bit overrun counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_xadc_drp_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        eos = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe, drp_drdy;
    logic [15:0] drp_di, drp_do;
    logic [15:0] voltage_tdata, current_tdata;
    logic        voltage_tvalid, current_tvalid;
    logic        voltage_tready = 1'b1;
    logic        current_tready = 1'b1;
    logic [15:0] overrun_count;
    logic        drp_timeout, busy;

    // Saturation instance
    logic        s_eos = 1'b0;
    logic [6:0]  s_daddr;
    logic        s_den, s_dwe, s_drdy;
    logic [15:0] s_di;
    logic [15:0] s_do = 16'h5550;
    logic [15:0] s_vdata, s_cdata;
    logic        s_vvalid, s_cvalid;
    logic        s_vready = 1'b0;
    logic        s_cready = 1'b0;
    logic [3:0]  s_overrun;
    logic        s_timeout, s_busy;

    // DRP responder controls
    logic        model_en     = 1'b1;
    logic        drop_current = 1'b0;
    logic        force_drdy   = 1'b0;
    logic [15:0] force_do     = '0;
    logic [15:0] v_data       = 16'hABC0;
    logic [15:0] c_data       = 16'h1230;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int den_count = 0;
    int v_beats   = 0;

    xadc_drp_sampler dut (
        .clk (clk), .rst (rst), .eos (eos),
        .drp_daddr (drp_daddr), .drp_den (drp_den), .drp_dwe (drp_dwe),
        .drp_di (drp_di), .drp_do (drp_do), .drp_drdy (drp_drdy),
        .voltage_tdata (voltage_tdata), .voltage_tvalid (voltage_tvalid),
        .voltage_tready (voltage_tready),
        .current_tdata (current_tdata), .current_tvalid (current_tvalid),
        .current_tready (current_tready),
        .overrun_count (overrun_count), .drp_timeout (drp_timeout), .busy (busy)
    );

    xadc_drp_sampler #(.OVERRUN_COUNT_WIDTH (4)) dut_sat (
        .clk (clk), .rst (rst), .eos (s_eos),
        .drp_daddr (s_daddr), .drp_den (s_den), .drp_dwe (s_dwe),
        .drp_di (s_di), .drp_do (s_do), .drp_drdy (s_drdy),
        .voltage_tdata (s_vdata), .voltage_tvalid (s_vvalid), .voltage_tready (s_vready),
        .current_tdata (s_cdata), .current_tvalid (s_cvalid), .current_tready (s_cready),
        .overrun_count (s_overrun), .drp_timeout (s_timeout), .busy (s_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Zero-wait DRP responder for the main instance.
    always @(posedge clk) begin
        logic       den_s;
        logic [6:0] addr_s;
        den_s  = drp_den;
        addr_s = drp_daddr;
        #1;
        if (model_en) begin
            drp_drdy = den_s && !(drop_current && addr_s == 7'h10);
            drp_do   = !drp_drdy ? 16'h0 : (addr_s == 7'h03 ? v_data : c_data);
        end else begin
            drp_drdy = force_drdy;
            drp_do   = force_do;
        end
    end

    always @(posedge clk) begin
        logic den_s;
        den_s = s_den;
        #1 s_drdy = den_s;
    end

    always @(negedge clk) begin
        if (drp_den) den_count++;
        if (voltage_tvalid && voltage_tready) v_beats++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // eos high for one cycle; that cycle becomes cycle 0 (t0).
    task automatic pulse_eos();
        @(posedge clk); #1 eos = 1'b1; t0 = cyc;
        @(posedge clk); #1 eos = 1'b0;
    endtask

    // Advance to the negedge of cycle t0+n.
    task automatic at_cycle(input int n);
        while (cyc < t0 + n) begin @(posedge clk); #1; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (drp_den !== 1'b0) begin n_fail++; $display("FAIL reset_den: got %b expected 0", drp_den); end
        n_checks++; if (drp_daddr !== 7'h0) begin n_fail++; $display("FAIL reset_daddr: got %h expected 00", drp_daddr); end
        n_checks++; if ({drp_dwe, drp_di} !== 17'h0) begin n_fail++; $display("FAIL reset_dwe_di: got %h expected 0", {drp_dwe, drp_di}); end
        n_checks++; if ({voltage_tvalid, current_tvalid, busy, drp_timeout} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {voltage_tvalid, current_tvalid, busy, drp_timeout}); end
        n_checks++; if ({voltage_tdata, current_tdata, overrun_count} !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {voltage_tdata, current_tdata, overrun_count}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        do_reset();
        v_data = 16'hABC0; c_data = 16'h1230;
        pulse_eos();
        at_cycle(1);
        n_checks++; if ({drp_den, drp_daddr} !== {1'b1, 7'h03}) begin n_fail++; $display("FAIL nom_den_v: got den=%b addr=%h expected den=1 addr=03", drp_den, drp_daddr); end
        at_cycle(2);
        n_checks++; if ({drp_den, drp_daddr} !== {1'b1, 7'h10}) begin n_fail++; $display("FAIL nom_den_c: got den=%b addr=%h expected den=1 addr=10", drp_den, drp_daddr); end
        at_cycle(3);
        n_checks++; if ({drp_den, drp_daddr} !== {1'b0, 7'h10}) begin n_fail++; $display("FAIL nom_addr_hold: got den=%b addr=%h expected den=0 addr=10", drp_den, drp_daddr); end
        at_cycle(4);
        n_checks++; if ({voltage_tvalid, current_tvalid, busy} !== 3'b001) begin n_fail++; $display("FAIL nom_commit: got v/c/busy=%b expected 001", {voltage_tvalid, current_tvalid, busy}); end
        at_cycle(5);
        n_checks++; if ({voltage_tvalid, current_tvalid} !== 2'b11) begin n_fail++; $display("FAIL nom_tvalid: got %b expected 11", {voltage_tvalid, current_tvalid}); end
        n_checks++; if (voltage_tdata !== 16'hABC0) begin n_fail++; $display("FAIL nom_vdata: got %h expected abc0", voltage_tdata); end
        n_checks++; if (current_tdata !== 16'h1230) begin n_fail++; $display("FAIL nom_cdata: got %h expected 1230", current_tdata); end
        n_checks++; if ({overrun_count, busy} !== 17'h0) begin n_fail++; $display("FAIL nom_overrun_busy: got %h expected 0", {overrun_count, busy}); end
        at_cycle(6);
        n_checks++; if ({voltage_tvalid, current_tvalid} !== 2'b00) begin n_fail++; $display("FAIL nom_drain: got %b expected 00", {voltage_tvalid, current_tvalid}); end
    endtask

    task automatic test_back_to_back_overrun();
        do_reset();
        voltage_tready = 1'b0; current_tready = 1'b0;
        v_data = 16'h1110; c_data = 16'h2220;
        pulse_eos();
        at_cycle(6);
        n_checks++; if ({voltage_tvalid, current_tvalid} !== 2'b11) begin n_fail++; $display("FAIL bp_first_valid: got %b expected 11", {voltage_tvalid, current_tvalid}); end
        v_data = 16'h3330; c_data = 16'h4440;
        repeat (33) @(posedge clk);
        pulse_eos();
        at_cycle(10);
        n_checks++; if (overrun_count !== 16'd1) begin n_fail++; $display("FAIL bp_overrun: got %0d expected 1", overrun_count); end
        n_checks++; if (voltage_tdata !== 16'h1110) begin n_fail++; $display("FAIL bp_vdata_stable: got %h expected 1110", voltage_tdata); end
        n_checks++; if (current_tdata !== 16'h2220) begin n_fail++; $display("FAIL bp_cdata_stable: got %h expected 2220", current_tdata); end
        n_checks++; if ({voltage_tvalid, current_tvalid, busy} !== 3'b110) begin n_fail++; $display("FAIL bp_held: got v/c/busy=%b expected 110", {voltage_tvalid, current_tvalid, busy}); end
        voltage_tready = 1'b1;
        @(negedge clk);
        n_checks++; if ({voltage_tvalid, current_tvalid} !== 2'b01) begin n_fail++; $display("FAIL bp_independent_drain: got %b expected 01", {voltage_tvalid, current_tvalid}); end
        current_tready = 1'b1;
        @(negedge clk);
        n_checks++; if ({voltage_tvalid, current_tvalid} !== 2'b00) begin n_fail++; $display("FAIL bp_drained: got %b expected 00", {voltage_tvalid, current_tvalid}); end
    endtask

    task automatic test_queued_eos();
        int den_base, beat_base;
        do_reset();
        v_data = 16'h0AA0; c_data = 16'h0BB0;
        den_base = den_count; beat_base = v_beats;
        pulse_eos();
        at_cycle(3);
        eos = 1'b1;
        @(negedge clk);
        @(negedge clk);
        eos = 1'b0;
        at_cycle(30);
        n_checks++; if (den_count - den_base !== 4) begin n_fail++; $display("FAIL q_den_pulses: got %0d expected 4", den_count - den_base); end
        n_checks++; if (v_beats - beat_base !== 2) begin n_fail++; $display("FAIL q_pairs: got %0d expected 2", v_beats - beat_base); end
        n_checks++; if ({busy, voltage_tvalid, current_tvalid} !== 3'b000) begin n_fail++; $display("FAIL q_idle: got busy/v/c=%b expected 000", {busy, voltage_tvalid, current_tvalid}); end
        at_cycle(60);
        n_checks++; if (den_count - den_base !== 4) begin n_fail++; $display("FAIL q_no_extra_den: got %0d expected 4", den_count - den_base); end
    endtask

    task automatic test_timeout();
        do_reset();
        drop_current = 1'b1;
        pulse_eos();
        at_cycle(66);
        n_checks++; if ({drp_timeout, busy} !== 2'b01) begin n_fail++; $display("FAIL to_before: got timeout/busy=%b expected 01", {drp_timeout, busy}); end
        at_cycle(67);
        n_checks++; if ({drp_timeout, busy} !== 2'b10) begin n_fail++; $display("FAIL to_expired: got timeout/busy=%b expected 10", {drp_timeout, busy}); end
        n_checks++; if ({voltage_tvalid, current_tvalid} !== 2'b00) begin n_fail++; $display("FAIL to_no_valid: got %b expected 00", {voltage_tvalid, current_tvalid}); end
        drop_current = 1'b0;
        v_data = 16'hC0D0; c_data = 16'hE0F0;
        pulse_eos();
        at_cycle(5);
        n_checks++; if ({voltage_tvalid, current_tvalid, voltage_tdata, current_tdata} !== {2'b11, 16'hC0D0, 16'hE0F0}) begin n_fail++; $display("FAIL to_recover: got v/c=%b data=%h/%h expected 11 c0d0/e0f0", {voltage_tvalid, current_tvalid}, voltage_tdata, current_tdata); end
        n_checks++; if (drp_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", drp_timeout); end
    endtask

    task automatic test_reset_mid_op();
        int den_base;
        model_en = 1'b0;
        pulse_eos();
        at_cycle(2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
        rst = 1'b0;
        #1;
        n_checks++; if ({drp_den, drp_daddr, voltage_tvalid, current_tvalid, busy, drp_timeout} !== 12'h0) begin n_fail++; $display("FAIL rm_ctrl_zero: got %h expected 0", {drp_den, drp_daddr, voltage_tvalid, current_tvalid, busy, drp_timeout}); end
        n_checks++; if ({voltage_tdata, current_tdata, overrun_count} !== 48'h0) begin n_fail++; $display("FAIL rm_data_zero: got %h expected 0", {voltage_tdata, current_tdata, overrun_count}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        den_base = den_count;
        @(posedge clk); #1 force_drdy = 1'b1; force_do = 16'hDEA0;
        @(posedge clk); #1 force_drdy = 1'b0; force_do = 16'h0;
        repeat (10) @(negedge clk);
        n_checks++; if ({busy, voltage_tvalid, current_tvalid} !== 3'b000) begin n_fail++; $display("FAIL rm_late_drdy: got busy/v/c=%b expected 000", {busy, voltage_tvalid, current_tvalid}); end
        n_checks++; if (overrun_count !== 16'd0 || den_count != den_base) begin n_fail++; $display("FAIL rm_quiet: got overrun=%0d den=%0d expected 0 0", overrun_count, den_count - den_base); end
        model_en = 1'b1;
    endtask

    task automatic s_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 s_eos = 1'b1;
            @(posedge clk); #1 s_eos = 1'b0;
            repeat (8) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        s_pulse(15);
        n_checks++; if ({s_vvalid, s_overrun} !== {1'b1, 4'hE}) begin n_fail++; $display("FAIL sat_14: got valid=%b count=%h expected 1 e", s_vvalid, s_overrun); end
        s_pulse(1);
        n_checks++; if (s_overrun !== 4'hF) begin n_fail++; $display("FAIL sat_15: got %h expected f", s_overrun); end
        s_pulse(5);
        n_checks++; if (s_overrun !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h expected f", s_overrun); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back_overrun();
        test_queued_eos();
        test_timeout();
        test_reset_mid_op();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_drp_sampler.md
Name: xadc_drp_sampler

Overview:
- Upstream producer for the XADC packetizer. On each XADC end-of-sequence pulse it reads one voltage and one current-monitor result register over the DRP.
- It presents the pair as two 16-bit AXI-Stream sources, which the packetizer consumes together.
- Pairs are always committed atomically: both channels get a new sample in the same cycle, or neither does.
- Sits between the XADC primitive's DRP port and the packetizer's two sink streams.

Parameters:
VOLTAGE_CHANNEL_ADDR, 7'h03, DRP address of the voltage result register (VP/VN)
CURRENT_CHANNEL_ADDR, 7'h10, DRP address of the current-monitor result register (VAUX0)
DRP_TIMEOUT_CYCLES, 64, maximum cycles to wait for drp_drdy after a read request
OVERRUN_COUNT_WIDTH, 16, width of the saturating overrun counter

Ports:
clk  input  1  system clock, shared by the XADC DRP and both output streams
rst  input  1  asynchronous, active-low reset
eos  input  1  XADC end-of-sequence pulse, one cycle wide
drp_daddr  output  7  DRP address
drp_den  output  1  DRP enable, one-cycle pulse per request
drp_dwe  output  1  DRP write enable, tied 0 (read-only block)
drp_di  output  16  DRP write data, tied 0
drp_do  input  16  DRP read data
drp_drdy  input  1  DRP read-data valid
voltage_tdata  output  16  raw DRP word; sample in [XADC_DRP_SAMPLE_MSB_IDX:XADC_DRP_SAMPLE_LSB_IDX]
voltage_tvalid  output  1  AXIS valid
voltage_tready  input  1  AXIS ready
current_tdata  output  16  as voltage_tdata
current_tvalid  output  1  AXIS valid
current_tready  input  1  AXIS ready
overrun_count  output  OVERRUN_COUNT_WIDTH  pairs dropped because an output slot was still occupied; saturating
drp_timeout  output  1  sticky; set when any DRP read times out
busy  output  1  high whenever state is not SAMPLER_IDLE

Behaviour:
- Reset (rst low, asynchronous) forces:
  - all outputs to 0;
  - state to SAMPLER_IDLE;
  - the pending flag and capture registers cleared;
  - any in-flight DRP read abandoned.
- States and transitions:
  - SAMPLER_IDLE: on eos or pending, pulse drp_den with drp_daddr = VOLTAGE_CHANNEL_ADDR, clear pending, go to SAMPLER_WAIT_VOLTAGE.
  - SAMPLER_WAIT_VOLTAGE: on drp_drdy, capture drp_do into voltage_hold, pulse drp_den with drp_daddr = CURRENT_CHANNEL_ADDR, go to SAMPLER_WAIT_CURRENT.
  - SAMPLER_WAIT_CURRENT: on drp_drdy, capture drp_do into current_hold, go to SAMPLER_COMMIT.
  - SAMPLER_COMMIT: define free_x = !x_tvalid || x_tready.
    - If free_v && free_c: register both holds onto tdata, assert both tvalid next cycle.
    - Otherwise: discard the pair and increment overrun_count (no change at all-ones).
    - Go to SAMPLER_IDLE in either case.
- drp_den is high for exactly one cycle per request. drp_daddr holds its value until the next request.
- Timeout: a per-wait cycle counter runs in both WAIT states.
  - When it reaches DRP_TIMEOUT_CYCLES without drp_drdy: set drp_timeout, discard any captured data, return to SAMPLER_IDLE.
  - The counter resets on each den pulse.
- eos while not SAMPLER_IDLE sets pending; only one sequence is queued. Further eos pulses while pending is set are ignored and not counted.
- drp_drdy in SAMPLER_IDLE or SAMPLER_COMMIT is ignored.
- Output stream handshake:
  - x_tvalid clears on the cycle after x_tvalid && x_tready.
  - The two channels drain independently.
  - tdata is stable while tvalid is high and not accepted.
- Latency, with eos at cycle 0 and zero-wait DRP (drdy the cycle after den):
  - den(V) at cycle 1
  - drdy(V) at cycle 2, den(C) also at cycle 2
  - drdy(C) at cycle 3
  - COMMIT at cycle 4
  - tvalid high at cycle 5

Decomposition:
- xadc_drp_package receives:
  - the xadc_drp_sampler_state_t enum (SAMPLER_IDLE, SAMPLER_WAIT_VOLTAGE, SAMPLER_WAIT_CURRENT, SAMPLER_COMMIT);
  - default address constants XADC_DRP_ADDR_VPVN and XADC_DRP_ADDR_VAUX0.
- XADC_DRP_SAMPLE_MSB_IDX/LSB_IDX are reused unchanged.
- One sub-module is natural: xadc_drp_read_port. It owns den pulse generation, the timeout counter, and drdy capture, and is instantiated once and shared by both reads.

Test Plan:
- Nominal pair: DRP model returns 16'hABC0 (V) and 16'h1230 (C), tready held 1, eos at cycle 0.
  - Required: den at cycles 1 and 2 with addr 7'h03 then 7'h10.
  - Required: both tvalid at cycle 5 with exact data; overrun_count = 0.
- Backpressure overrun: current_tready held 0, two eos 40 cycles apart.
  - Required: first pair held on both streams; second pair dropped; overrun_count = 1.
  - Required: voltage_tdata from the first pair unchanged.
- Queued eos: second eos arrives while in SAMPLER_WAIT_CURRENT, third eos one cycle later.
  - Required: exactly two sequences read (four den pulses).
  - Required: after both pairs are drained, busy is low and no further den pulses occur.
- DRP timeout: model never asserts drdy for the current read.
  - Required: at 64 cycles after den(C), drp_timeout = 1, state SAMPLER_IDLE, no tvalid.
  - Required: the next eos completes normally.
- Reset mid-operation: rst low during SAMPLER_WAIT_VOLTAGE, then released; a late drdy arrives after release.
  - Required: all outputs 0 during reset; the late drdy is ignored; overrun_count = 0.
- Saturation: preload via 2^16+3 forced overruns (or a reduced OVERRUN_COUNT_WIDTH of 4 with 20 overruns).
  - Required: counter holds all-ones and does not wrap.
